sd_dat_crc_tx: RTL and testbench

Transmit framer for one SD data line. It accepts a block of bytes over a valid/ready stream and sequences the serial CRC-16 generator. It drives the DAT line as: start bit, 8·N data bits MSB-first, 16 CRC bits MSB-first, end bit. It sits between the data FIFO and the DAT pad driver and gates the card clock when the FIFO underruns.

---
 rtl/sd_pkg.sv | 25 ++
 rtl/sd_crc16_serial.sv | 41 ++++
 rtl/sd_dat_crc_tx.sv | 204 ++++++++++++++++++++
 tb/tb_sd_dat_crc_tx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT transmit path.
//   state_e     : framer states (IDLE, START, DATA, CRC, STOP)
//   CRC16_POLY  : CCITT polynomial x^16+x^12+x^5+1 (implicit x^16)
//   CRC16_INIT  : generator value after clear
//   crc16_step  : advance the CRC by one serial bit, MSB-first
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CRC,
    STOP
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Serial CRC-16 (CCITT) generator, one bit per enabled cycle.
//   CLK     in   system clock
//   RST     in   synchronous active-high reset
//   clear   in   load CRC16_INIT (wins over enable)
//   enable  in   shift bit_in into the CRC this cycle
//   bit_in  in   serial data bit
//   crc     out  current CRC value
module sd_crc16_serial
  import sd_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC16_INIT;
    end else if (enable) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_dat_crc_tx.sv
// Transmit framer for one SD DAT line: start bit, 8*BLOCK_BYTES data bits
// MSB-first, 16 CRC bits MSB-first, end bit. Stalls with the card clock
// gated when the byte holding register is empty at a byte boundary.
//   CLK, RST    in   clock, synchronous active-high reset
//   start       in   begin a block (ignored while busy)
//   abort       in   return to idle immediately, no done
//   data_in     in   byte stream data, accepted on data_valid & data_ready
//   data_valid  in
//   data_ready  out
//   DAT_OUT     out  registered DAT line value
//   DAT_OE      out  pad output enable
//   sd_clk_en   out  high in each cycle a new DAT bit is presented
//   busy        out  high outside IDLE
//   done        out  one-cycle completion pulse
module sd_dat_crc_tx
  import sd_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       DAT_OUT,
  output logic       DAT_OE,
  output logic       sd_clk_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NBITS = 8 * BLOCK_BYTES;
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned AW    = $clog2(BLOCK_BYTES + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      crc_idx_q, crc_idx_d;
  logic [AW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            dat_q, dat_d;
  logic            oe_q, oe_d;
  logic            clk_en_q, clk_en_d;
  logic            done_q, done_d;

  logic            accept;
  logic            load;
  logic            advance;
  logic            tx_bit;
  logic            crc_clear;
  logic            crc_en;
  logic [15:0]     crc_val;

  sd_crc16_serial u_crc (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (tx_bit),
    .crc    (crc_val)
  );

  assign busy       = (state_q != IDLE);
  assign data_ready = busy & ~hold_full_q & (acc_cnt_q < AW'(BLOCK_BYTES));
  assign accept     = data_valid & data_ready;

  // The state names the bit that the next edge loads into DAT_OUT, so the
  // line lags the state by one cycle; done is raised while leaving the
  // end-bit cycle, i.e. in IDLE while the pad is still enabled.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    crc_idx_d   = crc_idx_q;
    acc_cnt_d   = acc_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    dat_d       = dat_q;
    oe_d        = oe_q;
    clk_en_d    = 1'b0;
    done_d      = 1'b0;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    tx_bit      = 1'b1;
    load        = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      IDLE: begin
        crc_clear = 1'b1;
        dat_d     = 1'b1;
        oe_d      = 1'b0;
        done_d    = oe_q;
        bit_cnt_d = '0;
        crc_idx_d = '0;
        acc_cnt_d = '0;
        if (start) begin
          state_d = START;
        end
      end
      START: begin
        dat_d    = 1'b0;
        oe_d     = 1'b1;
        clk_en_d = 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        if (bit_cnt_q[2:0] == 3'd0) begin
          // Byte boundary: an empty holding register stalls the line.
          load    = hold_full_q;
          advance = hold_full_q;
          tx_bit  = hold_q[7];
          if (hold_full_q) begin
            shift_d = {hold_q[6:0], 1'b0};
          end
        end else begin
          advance = 1'b1;
          tx_bit  = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end
        if (advance) begin
          dat_d    = tx_bit;
          clk_en_d = 1'b1;
          crc_en   = 1'b1;
          if (bit_cnt_q == BW'(NBITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = CRC;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      CRC: begin
        dat_d     = crc_val[4'd15 - crc_idx_q];
        clk_en_d  = 1'b1;
        crc_idx_d = crc_idx_q + 4'd1;
        if (crc_idx_q == 4'd15) begin
          state_d = STOP;
        end
      end
      STOP: begin
        dat_d    = 1'b1;
        clk_en_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      hold_d    = data_in;
      acc_cnt_d = acc_cnt_q + AW'(1);
    end
    hold_full_d = (hold_full_q & ~load) | accept;

    if (abort) begin
      state_d     = IDLE;
      dat_d       = 1'b1;
      oe_d        = 1'b0;
      clk_en_d    = 1'b0;
      done_d      = 1'b0;
      hold_full_d = 1'b0;
      acc_cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      crc_idx_q   <= '0;
      acc_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dat_q       <= 1'b1;
      oe_q        <= 1'b0;
      clk_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      crc_idx_q   <= crc_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dat_q       <= dat_d;
      oe_q        <= oe_d;
      clk_en_q    <= clk_en_d;
      done_q      <= done_d;
    end
  end

  assign DAT_OUT   = dat_q;
  assign DAT_OE    = oe_q;
  assign sd_clk_en = clk_en_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sd_dat_crc_tx.sv
module tb_sd_dat_crc_tx;

  localparam int D1   = 0;
  localparam int D2   = 1;
  localparam int D512 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [3];
  logic       start_s [3];
  logic       abort_s [3];
  logic [7:0] din_s   [3];
  logic       valid_s [3];
  logic       ready_s [3];
  logic       dout_s  [3];
  logic       oe_s    [3];
  logic       clken_s [3];
  logic       busy_s  [3];
  logic       done_s  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sd_dat_crc_tx #(
      .BLOCK_BYTES(g == 0 ? 1 : (g == 1 ? 2 : 512))
    ) u_dut (
      .CLK        (clk),
      .RST        (rst_s[g]),
      .start      (start_s[g]),
      .abort      (abort_s[g]),
      .data_in    (din_s[g]),
      .data_valid (valid_s[g]),
      .data_ready (ready_s[g]),
      .DAT_OUT    (dout_s[g]),
      .DAT_OE     (oe_s[g]),
      .sd_clk_en  (clken_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_bytes [$];
  bit         obs_bits [$];
  bit         exp_bits [$];
  int         oe_cycles, stall_cycles, stall_hold_bad, done_cnt;

  // Reference CRC: remainder of M(x)*x^16 divided by G(x), by long division.
  function automatic logic [15:0] model_crc();
    bit          m [$];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    foreach (tx_bytes[i]) for (int b = 7; b >= 0; b--) m.push_back(tx_bytes[i][b]);
    repeat (16) m.push_back(1'b0);
    for (int i = 0; i + 16 < m.size(); i++)
      if (m[i]) for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ g[16-j];
    for (int k = 0; k < 16; k++) r[15-k] = m[m.size()-16+k];
    return r;
  endfunction

  function automatic void model_frame();
    logic [15:0] c;
    c = model_crc();
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    foreach (tx_bytes[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(tx_bytes[i][b]);
    for (int k = 15; k >= 0; k--) exp_bits.push_back(c[k]);
    exp_bits.push_back(1'b1);
  endfunction

  function automatic int first_diff();
    int n;
    n = (obs_bits.size() < exp_bits.size()) ? obs_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) if (obs_bits[i] != exp_bits[i]) return i;
    if (obs_bits.size() != exp_bits.size()) return n;
    return -1;
  endfunction

  function automatic logic [15:0] obs_crc(input int n);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      if (1 + 8*n + k < obs_bits.size()) r[15-k] = obs_bits[1 + 8*n + k];
    return r;
  endfunction

  function automatic void random_bytes(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endfunction

  // Drives one block on DUT d starting at a negedge and records the line.
  // Returns at the negedge of the done cycle (or just after an abort edge).
  task automatic run_frame(input int d, input int stall_byte, input int stall_thr,
                           input int abort_bit, input bit start_crc);
    int n, idx, budget;
    bit pend, fin;
    n = tx_bytes.size();
    obs_bits.delete();
    oe_cycles = 0; stall_cycles = 0; stall_hold_bad = 0; done_cnt = 0;
    idx = 0; pend = 0; fin = 0;
    budget = 8*n + 64 + stall_thr;
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      if (pend) idx++;
      pend = 0;
      if (oe_s[d]) begin
        oe_cycles++;
        if (clken_s[d]) obs_bits.push_back(dout_s[d]);
        else begin
          stall_cycles++;
          if (obs_bits.size() > 0 && dout_s[d] !== obs_bits[$]) stall_hold_bad++;
        end
      end
      if (done_s[d]) begin
        done_cnt++;
        fin = 1;
      end
      if (!fin && abort_bit > 0 && obs_bits.size() == 1 + abort_bit) begin
        abort_s[d] = 1'b1;
        valid_s[d] = 1'b0;
        @(negedge clk);
        abort_s[d] = 1'b0;
        fin = 1;
      end
      if (!fin) begin
        start_s[d] = start_crc && (obs_bits.size() == 1 + 8*n + 4);
        if (idx < n && !(idx == stall_byte && stall_cycles < stall_thr)) begin
          valid_s[d] = 1'b1;
          din_s[d]   = tx_bytes[idx];
        end else begin
          valid_s[d] = 1'b0;
        end
        pend = valid_s[d] && ready_s[d];
        @(negedge clk);
      end
    end
    valid_s[d] = 1'b0;
    start_s[d] = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: dut %0d no done within %0d cycles (got none, want done pulse)", d, budget);
    end
  endtask

  task automatic abort_cleanup(input int d);
    abort_s[d] = 1'b1;
    valid_s[d] = 1'b0;
    @(negedge clk);
    abort_s[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({dout_s[d], oe_s[d], clken_s[d], busy_s[d], done_s[d], ready_s[d]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_values dut%0d: got %b want 100000", d,
                 {dout_s[d], oe_s[d], clken_s[d], busy_s[d], done_s[d], ready_s[d]});
      end
    end
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int diff;
    tx_bytes.delete();
    tx_bytes.push_back(8'h01);
    model_frame();
    run_frame(D1, -1, 0, 0, 1'b0);
    diff = first_diff();
    checks++;
    if (diff != -1) begin
      errors++;
      $display("FAIL single_frame: first bad bit %0d (got len %0d, want len %0d)", diff, obs_bits.size(), exp_bits.size());
    end
    checks++;
    if (obs_crc(1) !== 16'h1021) begin
      errors++; $display("FAIL single_crc: got %h want 1021", obs_crc(1));
    end
    checks++;
    if (oe_cycles !== 26) begin
      errors++; $display("FAIL single_oe_len: got %0d want 26", oe_cycles);
    end
    checks++;
    if (oe_s[D1] !== 1'b0) begin
      errors++; $display("FAIL single_oe_with_done: got %b want 0", oe_s[D1]);
    end
    @(negedge clk);
    checks++;
    if (done_s[D1] !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got %b want 0", done_s[D1]);
    end
  endtask

  task automatic test_full_block();
    int diff;
    tx_bytes.delete();
    repeat (512) tx_bytes.push_back(8'hFF);
    model_frame();
    run_frame(D512, -1, 0, 0, 1'b0);
    diff = first_diff();
    checks++;
    if (diff != -1) begin
      errors++; $display("FAIL full_frame: first bad bit %0d (got len %0d, want %0d)", diff, obs_bits.size(), exp_bits.size());
    end
    checks++;
    if (obs_crc(512) !== 16'h7FA1) begin
      errors++; $display("FAIL full_crc: got %h want 7fa1", obs_crc(512));
    end
    checks++;
    if (oe_cycles !== 4114 || stall_cycles !== 0) begin
      errors++; $display("FAIL full_oe_len: got %0d/%0d stalls want 4114/0", oe_cycles, stall_cycles);
    end
    @(negedge clk);
    checks++;
    if (done_cnt + int'(done_s[D512]) !== 1) begin
      errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt + int'(done_s[D512]));
    end
  endtask

  task automatic test_random_blocks();
    int diff;
    for (int it = 0; it < 4; it++) begin
      random_bytes(2);
      model_frame();
      run_frame(D2, -1, 0, 0, 1'b0);
      diff = first_diff();
      checks++;
      if (diff != -1 || oe_cycles !== 34 || done_cnt !== 1) begin
        errors++;
        $display("FAIL random_block%0d: bad bit %0d oe %0d done %0d (want -1, 34, 1)", it, diff, oe_cycles, done_cnt);
      end
      if (($urandom & 1) != 0) @(negedge clk);
    end
  endtask

  task automatic test_underrun();
    int diff, thr;
    for (int it = 0; it < 2; it++) begin
      thr = (it == 0) ? 4 : int'($urandom_range(1, 8));
      random_bytes(2);
      tx_bytes[1][7] = ~tx_bytes[0][0];
      model_frame();
      run_frame(D2, 1, thr, 0, 1'b0);
      checks++;
      if (stall_cycles !== thr + 1) begin
        errors++; $display("FAIL underrun_len%0d: got %0d stall cycles want %0d", it, stall_cycles, thr + 1);
      end
      checks++;
      if (stall_hold_bad !== 0 || obs_bits[8] !== tx_bytes[0][0]) begin
        errors++; $display("FAIL underrun_hold%0d: bad holds %0d last bit %b want 0, %b", it, stall_hold_bad, obs_bits[8], tx_bytes[0][0]);
      end
      diff = first_diff();
      checks++;
      if (diff != -1 || oe_cycles !== 34 + thr + 1) begin
        errors++; $display("FAIL underrun_frame%0d: bad bit %0d oe %0d (want -1, %0d)", it, diff, oe_cycles, 35 + thr);
      end
    end
  endtask

  task automatic test_abort();
    int diff;
    random_bytes(2);
    run_frame(D2, -1, 0, 3, 1'b0);
    checks++;
    if ({oe_s[D2], dout_s[D2], busy_s[D2], done_s[D2], ready_s[D2]} !== 5'b01000) begin
      errors++;
      $display("FAIL abort_state: oe/dout/busy/done/ready got %b want 01000",
               {oe_s[D2], dout_s[D2], busy_s[D2], done_s[D2], ready_s[D2]});
    end
    @(negedge clk);
    checks++;
    if (done_s[D2] !== 1'b0 || oe_s[D2] !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: done %b oe %b want 0 0", done_s[D2], oe_s[D2]);
    end
    random_bytes(2);
    model_frame();
    run_frame(D2, -1, 0, 0, 1'b0);
    diff = first_diff();
    checks++;
    if (diff != -1 || obs_crc(2) !== model_crc() || done_cnt !== 1) begin
      errors++; $display("FAIL abort_recover: bad bit %0d crc %h want %h", diff, obs_crc(2), model_crc());
    end
  endtask

  task automatic test_start_in_crc();
    int diff;
    random_bytes(2);
    model_frame();
    run_frame(D2, -1, 0, 0, 1'b1);
    diff = first_diff();
    checks++;
    if (diff != -1 || oe_cycles !== 34 || done_cnt !== 1) begin
      errors++; $display("FAIL start_in_crc: bad bit %0d oe %0d done %0d (want -1, 34, 1)", diff, oe_cycles, done_cnt);
    end
    @(negedge clk);
    checks++;
    if (busy_s[D2] !== 1'b0) begin
      errors++; $display("FAIL start_in_crc_idle: busy got %b want 0", busy_s[D2]);
    end
  endtask

  task automatic test_back_to_back();
    random_bytes(2);
    run_frame(D2, -1, 0, 0, 1'b0);
    start_s[D2] = 1'b1;
    @(negedge clk);
    start_s[D2] = 1'b0;
    checks++;
    if (oe_s[D2] !== 1'b0 || done_s[D2] !== 1'b0 || busy_s[D2] !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: oe %b done %b busy %b want 0 0 1", oe_s[D2], done_s[D2], busy_s[D2]);
    end
    @(negedge clk);
    checks++;
    if ({oe_s[D2], dout_s[D2], clken_s[D2]} !== 3'b101) begin
      errors++; $display("FAIL b2b_start_bit: oe/dout/clken got %b want 101", {oe_s[D2], dout_s[D2], clken_s[D2]});
    end
    abort_cleanup(D2);
  endtask

  task automatic test_reset_mid_data();
    random_bytes(2);
    start_s[D2] = 1'b1;
    @(negedge clk);
    start_s[D2] = 1'b0;
    valid_s[D2] = 1'b1;
    din_s[D2]   = tx_bytes[0];
    repeat (6) @(negedge clk);
    checks++;
    if (oe_s[D2] !== 1'b1 || clken_s[D2] !== 1'b1) begin
      errors++; $display("FAIL rst_pre_data: oe %b clken %b want 1 1", oe_s[D2], clken_s[D2]);
    end
    rst_s[D2] = 1'b1;
    @(negedge clk);
    rst_s[D2] = 1'b0;
    checks++;
    if ({dout_s[D2], oe_s[D2], clken_s[D2], busy_s[D2], done_s[D2], ready_s[D2]} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_mid_data: got %b want 100000",
               {dout_s[D2], oe_s[D2], clken_s[D2], busy_s[D2], done_s[D2], ready_s[D2]});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready_s[D2] !== 1'b0) begin
        errors++; $display("FAIL rst_ready_low%0d: got %b want 0", i, ready_s[D2]);
      end
    end
    start_s[D2] = 1'b1;
    @(negedge clk);
    start_s[D2] = 1'b0;
    checks++;
    if (ready_s[D2] !== 1'b1) begin
      errors++; $display("FAIL rst_ready_after_start: got %b want 1", ready_s[D2]);
    end
    abort_cleanup(D2);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; abort_s[d] = 1'b0;
      din_s[d] = '0; valid_s[d] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_full_block();
    test_random_blocks();
    test_underrun();
    test_abort();
    test_start_in_crc();
    test_back_to_back();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
